// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions.
//   XLEN          : datapath width
//   NOP_INST      : bubble instruction (addi x0,x0,0)
//   fetch_state_t : fetch FSM states BOOT / RUN / HALT
package riscv_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      HALT
   } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// Pipeline register holding an instruction, its byte address and a valid bit.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   load              : capture d_inst / d_pc as a valid instruction
//   bubble            : insert BUBBLE_INST with valid=0 (wins over load)
//   d_inst, d_pc      : incoming instruction word and its address
//   q_inst, q_pc      : registered instruction word and address
//   q_valid           : q_inst is a real instruction
// With neither load nor bubble the register holds.
module ifid_reg
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] BUBBLE_INST = NOP_INST
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            bubble,
   input  logic [XLEN-1:0] d_inst,
   input  logic [XLEN-1:0] d_pc,
   output logic [XLEN-1:0] q_inst,
   output logic [XLEN-1:0] q_pc,
   output logic            q_valid
);

   logic [XLEN-1:0] inst_q, inst_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            valid_q, valid_d;

   always_comb begin
      inst_d  = inst_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      if (bubble) begin
         inst_d  = BUBBLE_INST;
         pc_d    = d_pc;
         valid_d = 1'b0;
      end else if (load) begin
         inst_d  = d_inst;
         pc_d    = d_pc;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inst_q  <= BUBBLE_INST;
         pc_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         inst_q  <= inst_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
      end
   end

   assign q_inst  = inst_q;
   assign q_pc    = pc_q;
   assign q_valid = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, IF/ID register, BOOT/RUN/HALT FSM.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   stall             : hold pc and IF/ID
//   redirect          : taken branch/jump; next fetch from redirect_target
//   halt_req          : stop fetching (sticky until reset)
//   imem_rdata        : combinational instruction word for imem_addr
//   imem_addr         : word index {2'b00, pc[31:2]}
//   pc                : current fetch byte address
//   ifid_inst/_pc/_valid : IF/ID register contents
//   halted            : FSM is in HALT
//   oob_fetch         : pc word index beyond IMEM_DEPTH while in RUN
//   fetch_count       : instructions delivered with ifid_valid=1
//   misalign_err      : only with FETCH_ALIGN_CHECK_EN; one-cycle pulse on a
//                       misaligned redirect, which also halts fetch
// Macro FETCH_ALIGN_CHECK_EN enables the misaligned-redirect check; otherwise
// redirect_target[1:0] are dropped.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_DEPTH = 256,
   parameter logic [31:0] NOP_INST   = riscv_pkg::NOP_INST
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       stall,
   input  logic                       redirect,
   input  logic [riscv_pkg::XLEN-1:0] redirect_target,
   input  logic                       halt_req,
   input  logic [riscv_pkg::XLEN-1:0] imem_rdata,
   output logic [riscv_pkg::XLEN-1:0] imem_addr,
   output logic [riscv_pkg::XLEN-1:0] pc,
   output logic [riscv_pkg::XLEN-1:0] ifid_inst,
   output logic [riscv_pkg::XLEN-1:0] ifid_pc,
   output logic                       ifid_valid,
   output logic                       halted,
   output logic                       oob_fetch,
   output logic [riscv_pkg::XLEN-1:0] fetch_count
`ifdef FETCH_ALIGN_CHECK_EN
   ,
   output logic                       misalign_err
`endif
);

   import riscv_pkg::*;

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] count_q, count_d;
   logic            halted_q, halted_d;
   logic            ifid_load;
   logic            ifid_bubble;
`ifdef FETCH_ALIGN_CHECK_EN
   logic            misalign_q, misalign_d;
`endif

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      count_d     = count_q;
      halted_d    = halted_q;
      ifid_load   = 1'b0;
      ifid_bubble = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_d  = 1'b0;
`endif
      unique case (state_q)
         BOOT: state_d = RUN;
         RUN: begin
            if (halt_req) begin
               state_d     = HALT;
               halted_d    = 1'b1;
               ifid_bubble = 1'b1;
            end else if (redirect) begin
               // Squash the wrong-path word currently on imem_rdata.
               ifid_bubble = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
               if (redirect_target[1:0] != 2'b00) begin
                  misalign_d = 1'b1;
                  state_d    = HALT;
                  halted_d   = 1'b1;
               end else begin
                  pc_d = redirect_target;
               end
`else
               pc_d = redirect_target & ~32'h3;
`endif
            end else if (!stall) begin
               ifid_load = 1'b1;
               pc_d      = pc_q + 32'd4;
               count_d   = count_q + 32'd1;
            end
         end
         HALT: state_d = HALT;
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= BOOT;
         pc_q     <= RESET_PC;
         count_q  <= '0;
         halted_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         count_q  <= count_d;
         halted_q <= halted_d;
`ifdef FETCH_ALIGN_CHECK_EN
         misalign_q <= misalign_d;
`endif
      end
   end

   ifid_reg #(
      .BUBBLE_INST (NOP_INST)
   ) u_ifid_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (ifid_load),
      .bubble  (ifid_bubble),
      .d_inst  (imem_rdata),
      .d_pc    (pc_q),
      .q_inst  (ifid_inst),
      .q_pc    (ifid_pc),
      .q_valid (ifid_valid)
   );

   assign pc          = pc_q;
   assign imem_addr   = {2'b00, pc_q[31:2]};
   assign halted      = halted_q;
   assign fetch_count = count_q;
   assign oob_fetch   = (state_q == RUN) && ({2'b00, pc_q[31:2]} >= IMEM_DEPTH);
`ifdef FETCH_ALIGN_CHECK_EN
   assign misalign_err = misalign_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed table, hand-written corner
// sequences and randomized traffic against a behavioural fetch model.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] WA  = 32'hA0A0_0001;
   localparam logic [31:0] WB  = 32'hB0B0_0002;
   localparam logic [31:0] WC  = 32'hC0C0_0003;
   localparam logic [31:0] WD  = 32'hD0D0_0004;
   localparam logic [31:0] WE  = 32'hE0E0_0005;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0, redirect = 1'b0, halt_req = 1'b0;
   logic [31:0] redirect_target = '0;
   logic [31:0] imem_rdata, imem_addr, pc, ifid_inst, ifid_pc, fetch_count;
   logic        ifid_valid, halted, oob_fetch;

   logic        w_rst_n = 1'b0;
   logic [31:0] w_imem_rdata, w_imem_addr, w_pc, w_ifid_inst, w_ifid_pc, w_fetch_count;
   logic        w_ifid_valid, w_halted, w_oob_fetch;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        misalign_err, w_misalign_err;
`endif

   logic [31:0] mem [256];

   int n_chk = 0;
   int n_pass = 0;

   // Memory contents: array in range, address-derived pattern beyond it.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a < 32'd256) return mem[a[7:0]];
      return a ^ 32'hA5A5_0000;
   endfunction

   assign imem_rdata   = mem_word(imem_addr);
   assign w_imem_rdata = mem_word(w_imem_addr);

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .halt_req        (halt_req),
      .imem_rdata      (imem_rdata),
      .imem_addr       (imem_addr),
      .pc              (pc),
      .ifid_inst       (ifid_inst),
      .ifid_pc         (ifid_pc),
      .ifid_valid      (ifid_valid),
      .halted          (halted),
      .oob_fetch       (oob_fetch),
      .fetch_count     (fetch_count)
`ifdef FETCH_ALIGN_CHECK_EN
      ,
      .misalign_err    (misalign_err)
`endif
   );

   fetch_unit #(
      .RESET_PC (32'hFFFF_FFFC)
   ) dut_w (
      .clk             (clk),
      .rst_n           (w_rst_n),
      .stall           (1'b0),
      .redirect        (1'b0),
      .redirect_target (32'h0),
      .halt_req        (1'b0),
      .imem_rdata      (w_imem_rdata),
      .imem_addr       (w_imem_addr),
      .pc              (w_pc),
      .ifid_inst       (w_ifid_inst),
      .ifid_pc         (w_ifid_pc),
      .ifid_valid      (w_ifid_valid),
      .halted          (w_halted),
      .oob_fetch       (w_oob_fetch),
      .fetch_count     (w_fetch_count)
`ifdef FETCH_ALIGN_CHECK_EN
      ,
      .misalign_err    (w_misalign_err)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- behavioural reference model ----------------
   logic        m_boot, m_halted, m_valid, m_mis;
   logic [31:0] m_pc, m_inst, m_ipc, m_cnt;

   task automatic model_reset();
      m_boot = 1'b1; m_halted = 1'b0; m_valid = 1'b0; m_mis = 1'b0;
      m_pc = 32'h0; m_inst = NOP; m_ipc = 32'h0; m_cnt = 32'h0;
   endtask

   task automatic model_step(input logic s, input logic r, input logic [31:0] t, input logic h);
      m_mis = 1'b0;
      if (m_boot) begin
         m_boot = 1'b0;
      end else if (!m_halted) begin
         if (h) begin
            m_halted = 1'b1; m_inst = NOP; m_valid = 1'b0;
         end else if (r) begin
            m_inst = NOP; m_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            if (t % 4 != 0) begin
               m_halted = 1'b1; m_mis = 1'b1;
            end else m_pc = t;
`else
            m_pc = t - (t % 4);
`endif
         end else if (!s) begin
            m_inst = mem_word(m_pc / 4); m_ipc = m_pc; m_valid = 1'b1;
            m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
         end
      end
   endtask

   task automatic check_model(input string tag);
      logic exp_oob;
      exp_oob = !m_boot && !m_halted && ((m_pc / 4) >= 256);
      chk({tag, ".pc"}, pc, m_pc);
      chk({tag, ".imem_addr"}, imem_addr, m_pc / 4);
      chk({tag, ".ifid_inst"}, ifid_inst, m_inst);
      chk({tag, ".ifid_valid"}, {31'b0, ifid_valid}, {31'b0, m_valid});
      if (m_valid) chk({tag, ".ifid_pc"}, ifid_pc, m_ipc);
      chk({tag, ".halted"}, {31'b0, halted}, {31'b0, m_halted});
      chk({tag, ".fetch_count"}, fetch_count, m_cnt);
      chk({tag, ".oob_fetch"}, {31'b0, oob_fetch}, {31'b0, exp_oob});
`ifdef FETCH_ALIGN_CHECK_EN
      chk({tag, ".misalign_err"}, {31'b0, misalign_err}, {31'b0, m_mis});
`endif
   endtask

   // One clock with the given controls, then model update and compare.
   task automatic cycle(input string tag, input logic s, input logic r,
                        input logic [31:0] t, input logic h);
      stall = s; redirect = r; redirect_target = t; halt_req = h;
      @(posedge clk);
      #1;
      model_step(s, r, t, h);
      check_model(tag);
   endtask

   task automatic do_reset();
      stall = 1'b0; redirect = 1'b0; halt_req = 1'b0; redirect_target = '0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic        s, r, h;
      logic [31:0] t;
      logic [31:0] e_pc, e_inst, e_ipc;
      logic        e_valid, e_halted;
      logic [31:0] e_cnt;
   } vec_t;

   vec_t tbl [13];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      mem[0] = WA; mem[1] = WB; mem[2] = WC; mem[3] = WD; mem[8] = WE;

      tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h0,  NOP, 32'h0,  1'b0, 1'b0, 32'd0};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h4,  WA,  32'h0,  1'b1, 1'b0, 32'd1};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h8,  WB,  32'h4,  1'b1, 1'b0, 32'd2};
      tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h8,  WB,  32'h4,  1'b1, 1'b0, 32'd2};
      tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h8,  WB,  32'h4,  1'b1, 1'b0, 32'd2};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h8,  WB,  32'h4,  1'b1, 1'b0, 32'd2};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'hC,  WC,  32'h8,  1'b1, 1'b0, 32'd3};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h10, WD,  32'hC,  1'b1, 1'b0, 32'd4};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h20, 32'h20, NOP, 32'h0,  1'b0, 1'b0, 32'd4};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h24, WE,  32'h20, 1'b1, 1'b0, 32'd5};
      tbl[10] = '{1'b0, 1'b1, 1'b1, 32'h40, 32'h24, NOP, 32'h0,  1'b0, 1'b1, 32'd5};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 32'h40, 32'h24, NOP, 32'h0,  1'b0, 1'b1, 32'd5};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h24, NOP, 32'h0,  1'b0, 1'b1, 32'd5};

      // Reset values while held in reset.
      #12;
      chk("rst.pc", pc, 32'h0);
      chk("rst.ifid_inst", ifid_inst, NOP);
      chk("rst.ifid_pc", ifid_pc, 32'h0);
      chk("rst.ifid_valid", {31'b0, ifid_valid}, 32'h0);
      chk("rst.halted", {31'b0, halted}, 32'h0);
      chk("rst.fetch_count", fetch_count, 32'h0);
      chk("rst.oob_fetch", {31'b0, oob_fetch}, 32'h0);

      do_reset();
      for (int i = 0; i < 13; i++) begin
         stall = tbl[i].s; redirect = tbl[i].r; halt_req = tbl[i].h;
         redirect_target = tbl[i].t;
         @(posedge clk);
         #1;
         chk($sformatf("tbl%0d.pc", i), pc, tbl[i].e_pc);
         chk($sformatf("tbl%0d.imem_addr", i), imem_addr, tbl[i].e_pc >> 2);
         chk($sformatf("tbl%0d.ifid_inst", i), ifid_inst, tbl[i].e_inst);
         chk($sformatf("tbl%0d.ifid_valid", i), {31'b0, ifid_valid}, {31'b0, tbl[i].e_valid});
         if (tbl[i].e_valid)
            chk($sformatf("tbl%0d.ifid_pc", i), ifid_pc, tbl[i].e_ipc);
         chk($sformatf("tbl%0d.halted", i), {31'b0, halted}, {31'b0, tbl[i].e_halted});
         chk($sformatf("tbl%0d.fetch_count", i), fetch_count, tbl[i].e_cnt);
         chk($sformatf("tbl%0d.oob_fetch", i), {31'b0, oob_fetch}, 32'h0);
      end

      // Out-of-range flag around word 256.
      do_reset();
      cycle("oob.boot", 1'b0, 1'b0, 32'h0, 1'b0);
      cycle("oob.redir", 1'b0, 1'b1, 32'h3FC, 1'b0);
      chk("oob.at_3fc", {31'b0, oob_fetch}, 32'h0);
      cycle("oob.adv", 1'b0, 1'b0, 32'h0, 1'b0);
      chk("oob.at_400", {31'b0, oob_fetch}, 32'h1);
      cycle("oob.adv2", 1'b0, 1'b0, 32'h0, 1'b0);

      // Misaligned redirect.
      do_reset();
      cycle("mis.boot", 1'b0, 1'b0, 32'h0, 1'b0);
      cycle("mis.adv", 1'b0, 1'b0, 32'h0, 1'b0);
      cycle("mis.redir", 1'b0, 1'b1, 32'h22, 1'b0);
`ifdef FETCH_ALIGN_CHECK_EN
      chk("mis.pulse", {31'b0, misalign_err}, 32'h1);
      chk("mis.halted", {31'b0, halted}, 32'h1);
      cycle("mis.after", 1'b0, 1'b0, 32'h0, 1'b0);
      chk("mis.pulse_end", {31'b0, misalign_err}, 32'h0);
`else
      chk("mis.pc", pc, 32'h20);
`endif

      // Asynchronous reset while stalled.
      do_reset();
      cycle("ar.boot", 1'b0, 1'b0, 32'h0, 1'b0);
      cycle("ar.adv1", 1'b0, 1'b0, 32'h0, 1'b0);
      cycle("ar.adv2", 1'b0, 1'b0, 32'h0, 1'b0);
      cycle("ar.stall", 1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("ar.pc", pc, 32'h0);
      chk("ar.ifid_inst", ifid_inst, NOP);
      chk("ar.ifid_pc", ifid_pc, 32'h0);
      chk("ar.ifid_valid", {31'b0, ifid_valid}, 32'h0);
      chk("ar.fetch_count", fetch_count, 32'h0);
      chk("ar.halted", {31'b0, halted}, 32'h0);
      stall = 1'b0;

      // pc wrap on the RESET_PC=0xFFFFFFFC instance.
      @(negedge clk);
      w_rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("wrap.boot_pc", w_pc, 32'hFFFF_FFFC);
      chk("wrap.boot_valid", {31'b0, w_ifid_valid}, 32'h0);
      chk("wrap.oob_run", {31'b0, w_oob_fetch}, 32'h1);
      @(posedge clk);
      #1;
      chk("wrap.pc", w_pc, 32'h0);
      chk("wrap.ifid_pc", w_ifid_pc, 32'hFFFF_FFFC);
      chk("wrap.ifid_inst", w_ifid_inst, mem_word(32'h3FFF_FFFF));
      chk("wrap.count", w_fetch_count, 32'd1);

      // Randomized traffic against the model, including halts and resets.
      for (int blk = 0; blk < 5; blk++) begin
         do_reset();
         for (int c = 0; c < 150; c++) begin
            logic s, r, h;
            logic [31:0] t;
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 7) == 0);
            h = ($urandom_range(0, 119) == 0);
            t = $urandom_range(0, 300) * 4;
            if ($urandom_range(0, 7) == 0) t = t + $urandom_range(1, 3);
            cycle($sformatf("rnd%0d_%0d", blk, c), s, r, t, h);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
